// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of a 5-stage MIPS pipeline. Holds the PC, drives
// the instruction-memory address and picks the next PC from sequential,
// branch, j/jal and jr sources resolved in ID. On a taken control transfer
// the wrong-path instruction is squashed to a NOP. Saturating fetch and
// stall counters and a sticky misaligned-target flag are kept.
//
// Parameters
//   RESET_PC    PC loaded on reset
//   IMEM_WORDS  instruction memory depth in words (fetch beyond it -> NOP)
//   CNT_W       width of the saturating performance counters
//
// Ports
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   stall               hold PC; redirect inputs ignored while high
//   branchTaken/Target  taken branch and its target (from ID)
//   jump/jumpIndex      j/jal and instr[25:0]
//   pcAdd4ID            PC+4 of the ID instruction (upper nibble for jumps)
//   jr/jrTarget         jr and forwarded rs value
//   imemAddr            instruction memory byte address (= pc)
//   imemData            combinational instruction memory read data
//   pcAdd4IF            pc + 4, to IF/ID
//   instructionIF       fetched instruction or NOP, to IF/ID
//   fetchCount          instructions handed to IF/ID (not stalled/squashed)
//   stallCount          cycles with stall high
//   misalignErr         sticky: a jr/branch target had addr[1:0] != 0
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branchTaken,
  input  logic [31:0]      branchTarget,
  input  logic             jump,
  input  logic [25:0]      jumpIndex,
  input  logic [31:0]      pcAdd4ID,
  input  logic             jr,
  input  logic [31:0]      jrTarget,
  output logic [31:0]      imemAddr,
  input  logic [31:0]      imemData,
  output logic [31:0]      pcAdd4IF,
  output logic [31:0]      instructionIF,
  output logic [CNT_W-1:0] fetchCount,
  output logic [CNT_W-1:0] stallCount,
  output logic             misalignErr
);

  localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             misalign_q, misalign_d;
  logic             redirect;
  logic             in_range;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Redirects are only honoured when not stalled; ID re-resolves afterwards.
  assign redirect = !stall && (jr || jump || branchTaken);
  assign in_range = {2'b00, pc_q[31:2]} < IMEM_WORDS_W;

  assign imemAddr      = pc_q;
  assign pcAdd4IF      = pc_q + 32'd4;
  // The slot fetched while a redirect resolves is on the wrong path.
  assign instructionIF = (rst || redirect || !in_range) ? 32'h0 : imemData;
  assign fetchCount    = fetch_cnt_q;
  assign stallCount    = stall_cnt_q;
  assign misalignErr   = misalign_q;

  always_comb begin
    pc_d        = pc_q + 32'd4;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    misalign_d  = misalign_q;
    if (stall) begin
      pc_d        = pc_q;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (jr) begin
      pc_d = {jrTarget[31:2], 2'b00};
      if (jrTarget[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (jump) begin
      // Jump targets are word-aligned by construction.
      pc_d = {pcAdd4ID[31:28], jumpIndex, 2'b00};
    end else if (branchTaken) begin
      pc_d = {branchTarget[31:2], 2'b00};
      if (branchTarget[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (in_range) begin
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end
  end

  // PC register stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, branchTaken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0] branchTarget = '0, pcAdd4ID = '0, jrTarget = '0;
  logic [25:0] jumpIndex = '0;

  logic [31:0] a0, a1, a2, p0, p1, p2, i0, i1, i2, d0, d1, d2;
  logic [15:0] fc0, sc0, fc1, sc1;
  logic [3:0]  fc2, sc2;
  logic        e0, e1, e2;

  logic [31:0] addr_o[3], add4_o[3], ins_o[3], fc_o[3], sc_o[3];
  logic        err_o[3];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: defaults; 1: tiny memory; 2: wrapping PC, 4-bit counters.
  logic [31:0] P_RP[3]  = '{32'h0, 32'h0, 32'hFFFF_FFFC};
  int unsigned P_W[3]   = '{256, 4, 256};
  int unsigned P_MAX[3] = '{65535, 65535, 15};

  logic [31:0] m_pc[3];
  int unsigned m_fc[3], m_sc[3];
  logic        m_err[3];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[31:2] ^ 30'h2AAA_AAAA, 2'b11};
  endfunction

  assign d0 = rom(a0);
  assign d1 = rom(a1);
  assign d2 = rom(a2);

  always_comb begin
    addr_o[0] = a0; addr_o[1] = a1; addr_o[2] = a2;
    add4_o[0] = p0; add4_o[1] = p1; add4_o[2] = p2;
    ins_o[0]  = i0; ins_o[1]  = i1; ins_o[2]  = i2;
    fc_o[0] = {16'h0, fc0}; fc_o[1] = {16'h0, fc1}; fc_o[2] = {28'h0, fc2};
    sc_o[0] = {16'h0, sc0}; sc_o[1] = {16'h0, sc1}; sc_o[2] = {28'h0, sc2};
    err_o[0] = e0; err_o[1] = e1; err_o[2] = e2;
  end

  if_fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .jump(jump), .jumpIndex(jumpIndex),
    .pcAdd4ID(pcAdd4ID), .jr(jr), .jrTarget(jrTarget), .imemAddr(a0),
    .imemData(d0), .pcAdd4IF(p0), .instructionIF(i0), .fetchCount(fc0),
    .stallCount(sc0), .misalignErr(e0));

  if_fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(4), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .jump(jump), .jumpIndex(jumpIndex),
    .pcAdd4ID(pcAdd4ID), .jr(jr), .jrTarget(jrTarget), .imemAddr(a1),
    .imemData(d1), .pcAdd4IF(p1), .instructionIF(i1), .fetchCount(fc1),
    .stallCount(sc1), .misalignErr(e1));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(256), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .jump(jump), .jumpIndex(jumpIndex),
    .pcAdd4ID(pcAdd4ID), .jr(jr), .jrTarget(jrTarget), .imemAddr(a2),
    .imemData(d2), .pcAdd4IF(p2), .instructionIF(i2), .fetchCount(fc2),
    .stallCount(sc2), .misalignErr(e2));

  // ---------------- behavioural reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pc[i] = P_RP[i]; m_fc[i] = 0; m_sc[i] = 0; m_err[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (stall) begin
        if (m_sc[i] < P_MAX[i]) m_sc[i] = m_sc[i] + 1;
      end else if (jr) begin
        if (jrTarget % 4 != 0) m_err[i] = 1'b1;
        m_pc[i] = jrTarget - (jrTarget % 4);
      end else if (jump) begin
        m_pc[i] = {pcAdd4ID[31:28], jumpIndex, 2'b00};
      end else if (branchTaken) begin
        if (branchTarget % 4 != 0) m_err[i] = 1'b1;
        m_pc[i] = branchTarget - (branchTarget % 4);
      end else begin
        if (m_pc[i] / 4 < P_W[i] && m_fc[i] < P_MAX[i]) m_fc[i] = m_fc[i] + 1;
        m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endfunction

  function automatic logic [31:0] exp_ins(input int i);
    if (rst) return 32'h0;
    if (!stall && (jr || jump || branchTaken)) return 32'h0;
    if (m_pc[i] / 4 >= P_W[i]) return 32'h0;
    return rom(m_pc[i]);
  endfunction

  task automatic clear_ctl();
    stall = 0; branchTaken = 0; jump = 0; jr = 0;
    branchTarget = '0; pcAdd4ID = '0; jrTarget = '0; jumpIndex = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clear_ctl();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_ctl();
    rst = 0;
    #1 rst = 1;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (addr_o[i] !== P_RP[i]) begin n_fail++; $display("FAIL reset_addr[%0d]: got %h want %h", i, addr_o[i], P_RP[i]); end
      n_tests++; if (add4_o[i] !== P_RP[i] + 32'd4) begin n_fail++; $display("FAIL reset_add4[%0d]: got %h want %h", i, add4_o[i], P_RP[i] + 32'd4); end
      n_tests++; if (ins_o[i] !== 32'h0) begin n_fail++; $display("FAIL reset_ins[%0d]: got %h want 0", i, ins_o[i]); end
      n_tests++; if (fc_o[i] !== 32'h0 || sc_o[i] !== 32'h0 || err_o[i] !== 1'b0) begin n_fail++; $display("FAIL reset_cnt[%0d]: got fc=%0d sc=%0d err=%b want 0", i, fc_o[i], sc_o[i], err_o[i]); end
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++; if (a0 !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr: got %h want %h", a0, 32'(4 * k)); end
      n_tests++; if (i0 !== rom(32'(4 * k))) begin n_fail++; $display("FAIL seq_ins: got %h want %h", i0, rom(32'(4 * k))); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (fc0 !== 16'd4) begin n_fail++; $display("FAIL seq_fetchcnt: got %0d want 4", fc0); end
    n_tests++; if (fc1 !== 16'd4) begin n_fail++; $display("FAIL seq_fetchcnt_small: got %0d want 4", fc1); end
    // asynchronous reset, no clock edge in between
    rst = 1;
    #1;
    n_tests++; if (a0 !== 32'h0 || fc0 !== 16'd0 || sc0 !== 16'd0) begin n_fail++; $display("FAIL async_rst: got addr=%h fc=%0d sc=%0d want 0", a0, fc0, sc0); end
    n_tests++; if (i0 !== 32'h0) begin n_fail++; $display("FAIL async_rst_ins: got %h want 0", i0); end
    model_reset();
    tick();
    rst = 0;
    @(negedge clk);
    n_tests++; if (a0 !== 32'h0 || i0 !== rom(32'h0)) begin n_fail++; $display("FAIL first_fetch: got addr=%h ins=%h want 0 / %h", a0, i0, rom(32'h0)); end
  endtask

  task automatic test_stall();
    tick(); tick();                       // pc = 8, fetchCount = 2
    stall = 1; branchTaken = 1; branchTarget = 32'h40;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (a0 !== 32'h8) begin n_fail++; $display("FAIL stall_addr: got %h want 8", a0); end
      n_tests++; if (i0 !== rom(32'h8)) begin n_fail++; $display("FAIL stall_noskip: got %h want %h", i0, rom(32'h8)); end
      tick();
    end
    stall = 0; branchTaken = 0;
    @(negedge clk);
    n_tests++; if (a0 !== 32'h8) begin n_fail++; $display("FAIL stall_release_addr: got %h want 8", a0); end
    n_tests++; if (sc0 !== 16'd3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", sc0); end
    n_tests++; if (fc0 !== 16'd2) begin n_fail++; $display("FAIL stall_fetch_frozen: got %0d want 2", fc0); end
  endtask

  task automatic test_branch();
    tick(); tick();                       // pc = 0x10, fetchCount = 4
    branchTaken = 1; branchTarget = 32'h40;
    @(negedge clk);
    n_tests++; if (i0 !== 32'h0) begin n_fail++; $display("FAIL branch_squash: got %h want 0", i0); end
    tick();
    clear_ctl();
    @(negedge clk);
    n_tests++; if (a0 !== 32'h40) begin n_fail++; $display("FAIL branch_target: got %h want 40", a0); end
    n_tests++; if (fc0 !== 16'd4) begin n_fail++; $display("FAIL branch_fetchcnt: got %0d want 4", fc0); end
  endtask

  task automatic test_priority_jump();
    jr = 1; jrTarget = 32'h80; jump = 1; jumpIndex = 26'h3FF;
    pcAdd4ID = 32'h2000_0000; branchTaken = 1; branchTarget = 32'h40;
    tick();
    clear_ctl();
    @(negedge clk);
    n_tests++; if (a0 !== 32'h80) begin n_fail++; $display("FAIL prio_jr: got %h want 80", a0); end
    jump = 1; pcAdd4ID = 32'h1000_0004; jumpIndex = 26'h10;
    tick();
    clear_ctl();
    @(negedge clk);
    n_tests++; if (a0 !== 32'h1000_0040) begin n_fail++; $display("FAIL jump_target: got %h want 10000040", a0); end
    n_tests++; if (i0 !== 32'h0) begin n_fail++; $display("FAIL jump_oob_ins: got %h want 0", i0); end
  endtask

  task automatic test_misalign_range();
    jr = 1; jrTarget = 32'h46;
    tick();
    clear_ctl();
    @(negedge clk);
    n_tests++; if (a0 !== 32'h44) begin n_fail++; $display("FAIL misalign_addr: got %h want 44", a0); end
    n_tests++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL misalign_flag: got %b want 1", e0); end
    repeat (5) tick();
    @(negedge clk);
    n_tests++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b want 1", e0); end
    do_reset();
    n_tests++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b want 0", e0); end
    repeat (4) tick();
    @(negedge clk);
    n_tests++; if (a1 !== 32'h10 || i1 !== 32'h0) begin n_fail++; $display("FAIL range_oob: got addr=%h ins=%h want 10 / 0", a1, i1); end
    n_tests++; if (i0 !== rom(32'h10)) begin n_fail++; $display("FAIL range_inb: got %h want %h", i0, rom(32'h10)); end
    tick();
    @(negedge clk);
    n_tests++; if (a1 !== 32'h14) begin n_fail++; $display("FAIL range_advance: got %h want 14", a1); end
    n_tests++; if (fc1 !== 16'd4) begin n_fail++; $display("FAIL range_fetchcnt: got %0d want 4", fc1); end
  endtask

  task automatic test_wrap_saturation();
    do_reset();
    n_tests++; if (a2 !== 32'hFFFF_FFFC || p2 !== 32'h0) begin n_fail++; $display("FAIL wrap_add4: got addr=%h add4=%h want fffffffc / 0", a2, p2); end
    tick();
    @(negedge clk);
    n_tests++; if (a2 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", a2); end
    repeat (20) tick();
    @(negedge clk);
    n_tests++; if (fc2 !== 4'hF) begin n_fail++; $display("FAIL sat_fetch: got %h want f", fc2); end
    stall = 1;
    repeat (20) tick();
    stall = 0;
    @(negedge clk);
    n_tests++; if (sc2 !== 4'hF || fc2 !== 4'hF) begin n_fail++; $display("FAIL sat_stall: got sc=%h fc=%h want f / f", sc2, fc2); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom % 60) == 0;
      stall       = ($urandom % 4) == 0;
      jr          = ($urandom % 16) == 0;
      jump        = ($urandom % 12) == 0;
      branchTaken = ($urandom % 8) == 0;
      jrTarget     = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'h3FF);
      branchTarget = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'h3FF);
      pcAdd4ID     = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'h3FF);
      jumpIndex    = 26'($urandom & 32'hFF);
      if (rst) model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (addr_o[i] !== m_pc[i]) begin n_fail++; $display("FAIL rnd_addr[%0d] c%0d: got %h want %h", i, c, addr_o[i], m_pc[i]); end
        n_tests++; if (add4_o[i] !== m_pc[i] + 32'd4) begin n_fail++; $display("FAIL rnd_add4[%0d] c%0d: got %h want %h", i, c, add4_o[i], m_pc[i] + 32'd4); end
        n_tests++; if (ins_o[i] !== exp_ins(i)) begin n_fail++; $display("FAIL rnd_ins[%0d] c%0d: got %h want %h", i, c, ins_o[i], exp_ins(i)); end
        n_tests++; if (fc_o[i] !== m_fc[i]) begin n_fail++; $display("FAIL rnd_fetchcnt[%0d] c%0d: got %0d want %0d", i, c, fc_o[i], m_fc[i]); end
        n_tests++; if (sc_o[i] !== m_sc[i]) begin n_fail++; $display("FAIL rnd_stallcnt[%0d] c%0d: got %0d want %0d", i, c, sc_o[i], m_sc[i]); end
        n_tests++; if (err_o[i] !== m_err[i]) begin n_fail++; $display("FAIL rnd_err[%0d] c%0d: got %b want %b", i, c, err_o[i], m_err[i]); end
      end
      tick();
    end
    rst = 0;
    clear_ctl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_priority_jump();
    test_misalign_range();
    test_wrap_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
